// File: rtl/matrix_bank_row_scheduler.sv
// Row-read command scheduler: walks a matrix row by row, issuing one read per row with
// at most MAX_OUTSTANDING in flight. Optional abort input via MATRIX_BANK_SCHED_ABORT_EN.
module matrix_bank_row_scheduler #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int MAX_DIMENSION     = 1024,
  parameter int DATA_BYTES        = 4,
  parameter int MAX_OUTSTANDING   = 4,
  localparam int DIM_W   = $clog2(MAX_DIMENSION) + 1,
  localparam int BYTES_W = $clog2(MAX_DIMENSION * DATA_BYTES) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [AXI_ADDRESS_WIDTH-1:0] req_start_address,
  input  logic [DIM_W-1:0]             req_columns,
  input  logic [DIM_W-1:0]             req_rows,
  output logic                         rd_cmd_valid,
  input  logic                         rd_cmd_ready,
  output logic [AXI_ADDRESS_WIDTH-1:0] rd_cmd_address,
  output logic [BYTES_W-1:0]           rd_cmd_bytes,
  input  logic                         rd_done,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_partial,
  output logic                         busy
`ifdef MATRIX_BANK_SCHED_ABORT_EN
  ,
  input  logic                         abort
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIMENSION);
  localparam logic [3:0]       MAX_OUT_V = 4'(MAX_OUTSTANDING);

  state_t               state;
  logic [DIM_W-1:0]     rows_q;
  logic [DIM_W-1:0]     row_idx;
  logic [3:0]           outstanding;
  logic [3:0]           out_next;
  logic                 partial_q;
  logic                 cmd_fire;
  logic                 done_eff;
  logic                 abort_hit;
  logic                 last_row;
  logic                 rows_over;
  logic                 cols_over;
  logic                 zero_dim;
  logic [DIM_W-1:0]     rows_clamp;
  logic [DIM_W-1:0]     cols_clamp;
  logic [BYTES_W-1:0]   bytes_clamp;

`ifdef MATRIX_BANK_SCHED_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign rows_over   = (req_rows > MAX_DIM_V);
  assign cols_over   = (req_columns > MAX_DIM_V);
  assign zero_dim    = (req_rows == '0) || (req_columns == '0);
  assign rows_clamp  = rows_over ? MAX_DIM_V : req_rows;
  assign cols_clamp  = cols_over ? MAX_DIM_V : req_columns;
  assign bytes_clamp = BYTES_W'(cols_clamp) * BYTES_W'(DATA_BYTES);

  assign cmd_fire = rd_cmd_valid && rd_cmd_ready;
  // A completion with nothing in flight is stale (e.g. from before a reset) and is dropped.
  assign done_eff = rd_done && (outstanding != 4'd0);
  assign last_row = (row_idx == rows_q - DIM_W'(1));

  always_comb begin
    out_next = outstanding;
    if (cmd_fire && !done_eff) begin
      out_next = outstanding + 4'd1;
    end else if (!cmd_fire && done_eff) begin
      out_next = outstanding - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      rd_cmd_valid   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_partial   <= 1'b0;
      busy           <= 1'b0;
      rd_cmd_address <= '0;
      rd_cmd_bytes   <= '0;
      rows_q         <= '0;
      row_idx        <= '0;
      outstanding    <= '0;
      partial_q      <= 1'b0;
    end else begin
      outstanding <= out_next;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            rd_cmd_address <= req_start_address;
            rd_cmd_bytes   <= bytes_clamp;
            rows_q         <= rows_clamp;
            row_idx        <= '0;
            if (zero_dim) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_partial <= 1'b0;
              partial_q    <= 1'b0;
            end else begin
              state        <= ISSUE;
              rd_cmd_valid <= 1'b1;
              partial_q    <= rows_over || cols_over;
            end
          end
        end
        ISSUE: begin
          // Row length doubles as the stride between consecutive row addresses.
          if (cmd_fire) begin
            row_idx        <= row_idx + DIM_W'(1);
            rd_cmd_address <= rd_cmd_address + AXI_ADDRESS_WIDTH'(rd_cmd_bytes);
          end
          if (abort_hit) begin
            state        <= DRAIN;
            rd_cmd_valid <= 1'b0;
            partial_q    <= 1'b1;
          end else if (cmd_fire && last_row) begin
            state        <= DRAIN;
            rd_cmd_valid <= 1'b0;
          end else begin
            rd_cmd_valid <= (out_next < MAX_OUT_V);
          end
        end
        DRAIN: begin
          if (abort_hit) begin
            partial_q <= 1'b1;
          end
          if (out_next == 4'd0) begin
            state        <= RESP;
            resp_valid   <= 1'b1;
            resp_partial <= partial_q || abort_hit;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_partial <= 1'b0;
            busy         <= 1'b0;
            req_ready    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_bank_row_scheduler.sv
// Randomized bench for matrix_bank_row_scheduler: a read-master/requester model predicts
// every command address, flow-control output and completion cycle from the matrix rules.
module tb_matrix_bank_row_scheduler;

  localparam int AW      = 32;
  localparam int DW      = 11;
  localparam int BW      = 13;
  localparam int MAX_OUT = 4;
  localparam int MAX_DIM = 1024;
  localparam int ELEM_B  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_start_address;
  logic [DW-1:0] req_columns;
  logic [DW-1:0] req_rows;
  logic          rd_cmd_valid;
  logic          rd_cmd_ready;
  logic [AW-1:0] rd_cmd_address;
  logic [BW-1:0] rd_cmd_bytes;
  logic          rd_done;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_partial;
  logic          busy;
`ifdef MATRIX_BANK_SCHED_ABORT_EN
  logic          abort = 1'b0;
`endif

  matrix_bank_row_scheduler dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_start_address(req_start_address),
    .req_columns(req_columns),
    .req_rows(req_rows),
    .rd_cmd_valid(rd_cmd_valid),
    .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_address(rd_cmd_address),
    .rd_cmd_bytes(rd_cmd_bytes),
    .rd_done(rd_done),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_partial(resp_partial),
    .busy(busy)
`ifdef MATRIX_BANK_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  bit            active = 0;
  bit            pending = 0;
  bit            exp_partial = 0;
  bit            hold_done = 0;
  bit            spurious = 0;
  logic [AW-1:0] exp_q[$];
  logic [BW-1:0] exp_bytes = '0;
  int            tb_out = 0;
  int            done_q[$];
  int            dly_min = 1;
  int            dly_max = 6;
  int            rdy_pct = 70;
  int            n_issued = 0;
  int            first_done_cyc = -1;
  int            fifth_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected command stream for the request currently on the req_* inputs.
  task automatic accept_model();
    int r;
    int c;
    r = (int'(req_rows) > MAX_DIM) ? MAX_DIM : int'(req_rows);
    c = (int'(req_columns) > MAX_DIM) ? MAX_DIM : int'(req_columns);
    exp_q.delete();
    active = 1;
    if (r == 0 || c == 0) begin
      exp_partial = 0;
    end else begin
      exp_partial = (int'(req_rows) > MAX_DIM) || (int'(req_columns) > MAX_DIM);
      exp_bytes   = BW'(c * ELEM_B);
      for (int i = 0; i < r; i++) exp_q.push_back(req_start_address + AW'(i * c * ELEM_B));
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step();
    bit acc;
    bit exp_vld;
    bit exp_resp;
    exp_vld  = active && exp_q.size() > 0 && tb_out < MAX_OUT;
    exp_resp = active && exp_q.size() == 0 && tb_out == 0;
    check("cmd_vld", rd_cmd_valid, exp_vld);
    check("resp_vld", resp_valid, exp_resp);
    check("busy", busy, active);
    check("req_rdy", req_ready, !active);
    if (exp_resp) check("partial", resp_partial, exp_partial);

    acc          = pending && !active;
    req_valid    = acc || (active && $urandom_range(3) == 0);
    rd_cmd_ready = ($urandom_range(99) < rdy_pct);
    resp_ready   = ($urandom_range(1) == 1);
    rd_done      = spurious;
    if (!hold_done && done_q.size() > 0 && done_q[0] <= cyc) begin
      void'(done_q.pop_front());
      rd_done = 1'b1;
      if (first_done_cyc < 0) first_done_cyc = cyc;
    end

    if (exp_vld && rd_cmd_ready) begin
      check("cmd_addr", rd_cmd_address, exp_q[0]);
      check("cmd_bytes", rd_cmd_bytes, exp_bytes);
      void'(exp_q.pop_front());
      tb_out++;
      n_issued++;
      if (n_issued == 5) fifth_cyc = cyc;
      done_q.push_back(cyc + $urandom_range(dly_max, dly_min));
    end
    if (rd_done && tb_out > 0) tb_out--;
    if (exp_resp && resp_ready) active = 0;
    if (acc) begin
      accept_model();
      pending = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req_rdy", req_ready, 0);
    check("rst_cmd_vld", rd_cmd_valid, 0);
    check("rst_resp_vld", resp_valid, 0);
    check("rst_partial", resp_partial, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", rd_cmd_address, 0);
    check("rst_bytes", rd_cmd_bytes, 0);
    active = 0;
    pending = 0;
    exp_q.delete();
    done_q.delete();
    tb_out = 0;
    req_valid = 0;
    rd_cmd_ready = 0;
    rd_done = 0;
    resp_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_req(input logic [AW-1:0] st, input int rows, input int cols);
    req_start_address = st;
    req_rows          = DW'(rows);
    req_columns       = DW'(cols);
    pending           = 1;
  endtask

  task automatic wait_idle(input string tag);
    int budget = 30000;
    while ((pending || active) && budget > 0) begin
      step();
      budget--;
    end
    check(tag, budget > 0, 1);
    if (budget == 0) do_reset();
  endtask

  initial begin
    req_valid = 0;
    req_start_address = '0;
    req_columns = '0;
    req_rows = '0;
    rd_cmd_ready = 0;
    rd_done = 0;
    resp_ready = 0;
    #2;
    do_reset();

    // 3x16 matrix at 0x1000, always ready, completions 2 cycles after each command
    rdy_pct = 100; dly_min = 2; dly_max = 2;
    start_req(32'h0000_1000, 3, 16);
    wait_idle("t_basic");

    start_req(32'h0000_5000, 0, 7);
    wait_idle("t_zero_rows");
    start_req(32'h0000_6000, 5, 0);
    wait_idle("t_zero_cols");

    start_req(32'hFFFF_FFC0, 2, 16);
    wait_idle("t_wrap");

    // reset in the middle of issuing, then stale completions that must be ignored
    hold_done = 1;
    start_req(32'h0000_3000, 10, 8);
    repeat (4) step();
    check("mid_busy", busy, 1);
    do_reset();
    hold_done = 0;
    spurious = 1;
    repeat (3) step();
    spurious = 0;

    // outstanding limit with completions withheld
    n_issued = 0; first_done_cyc = -1; fifth_cyc = -1;
    dly_min = 1; dly_max = 1; hold_done = 1;
    start_req(32'h0000_2000, 8, 4);
    repeat (20) step();
    check("held_cmds", n_issued, 4);
    hold_done = 0;
    wait_idle("t_limit");
    check("fifth_after_done", fifth_cyc - first_done_cyc, 1);

    // oversized request is clamped
    rdy_pct = 70; dly_min = 1; dly_max = 6;
    n_issued = 0;
    start_req(32'h0000_0000, 2000, 4);
    wait_idle("t_clamp_rows");
    check("clamp_cmds", n_issued, 1024);

    for (int k = 0; k < 30; k++) begin
      int rows;
      int cols;
      int sel;
      sel  = $urandom_range(9);
      rows = (k % 12 == 5) ? $urandom_range(2047, 1025) : (sel == 0 ? 0 : $urandom_range(12, 1));
      sel  = $urandom_range(9);
      cols = (sel == 0) ? 0 : (sel == 1 ? $urandom_range(2047, 1025) : $urandom_range(64, 1));
      rdy_pct = $urandom_range(100, 30);
      dly_max = $urandom_range(8, 1);
      start_req($urandom, rows, cols);
      wait_idle("t_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
